// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/response and ram port signals of the memory access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_read, mem_write, mem_address, mem_byteenable, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_read, mem_write, mem_address, mem_byteenable, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit with alignment and range checking
// in front of a single-cycle-read ram.
module mem_access_unit #(
  parameter logic [31:0] offset = 32'h00000000,
  parameter int unsigned size   = 65536
) (
  input logic            clock,
  input logic            reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  state_t state, state_nx;
  logic        wr, sgn, bad, accept, acc;
  logic [1:0]  sz, lane;
  logic [31:0] addr, wdata, rel, fmt;
  logic [7:0]  b;
  logic [15:0] h;
  logic [3:0]  be;
  assign rel    = bus.req_addr - offset;
  assign bad    = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && |bus.req_addr[1:0]) ||
                  bus.req_addr < offset || (rel >> 2) >= size;
  assign accept = bus.req_valid && bus.req_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wr    <= 1'b0;
      sgn   <= 1'b0;
      sz    <= 2'b00;
      addr  <= 32'h0;
      wdata <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr    <= bus.req_write;
        sgn   <= bus.req_signed;
        sz    <= bus.req_size;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
      end
    end
  end
  // mem strobes and the response are masked combinationally by reset so an in-flight request is dropped
  always_comb begin
    state_nx           = state == IDLE ? (accept ? (bad ? ERR : ACCESS) : IDLE) :
                         state == ACCESS ? RESP : IDLE;
    lane               = addr[1:0];
    acc                = state == ACCESS && !reset;
    be                 = sz == 2'b00 ? 4'b0001 << lane : sz == 2'b01 ? 4'b0011 << lane : 4'b1111;
    b                  = bus.mem_rdata[{lane, 3'b000} +: 8];
    h                  = bus.mem_rdata[{addr[1], 4'b0000} +: 16];
    fmt                = sz == 2'b00 ? {{24{sgn & b[7]}}, b} :
                         sz == 2'b01 ? {{16{sgn & h[15]}}, h} : bus.mem_rdata;
    bus.req_ready      = state == IDLE && !reset;
    bus.mem_read       = acc && !wr;
    bus.mem_write      = acc && wr;
    bus.mem_byteenable = acc && wr ? be : 4'b0000;
    bus.mem_address    = acc ? (addr - offset) >> 2 : 32'h0;
    bus.mem_wdata      = acc ? (sz == 2'b00 ? {4{wdata[7:0]}} :
                                sz == 2'b01 ? {2{wdata[15:0]}} : wdata) : 32'h0;
    bus.resp_valid     = !reset && (state == RESP || state == ERR);
    bus.resp_error     = !reset && state == ERR;
    bus.resp_rdata     = state == RESP && !wr ? fmt : 32'h0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory access unit against a small byte-enabled ram model.
module tb_mem_access_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_wr = 0;
  logic [31:0] ram [0:63];
  mem_access_unit_if bus ();
  mem_access_unit dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (bus.mem_write) begin
      n_wr <= n_wr + 1;
      for (int k = 0; k < 4; k++)
        if (bus.mem_byteenable[k]) ram[bus.mem_address[5:0]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
    end
    if (bus.mem_read) bus.mem_rdata <= ram[bus.mem_address[5:0]];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic sg,
                       input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
    bus.req_size = sz; bus.req_signed = sg; bus.req_wdata = wd;
  endtask
  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic sg, input logic [31:0] wd, input logic err, input logic [31:0] e_addr,
                     input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rd);
    @(negedge clock);
    drive(w, a, sz, sg, wd);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'h1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0; bus.req_wdata = ~wd; bus.req_addr = a ^ 32'h4; bus.req_size = ~sz;
    @(negedge clock);
    if (err) begin
      check({tag, ".err_valid"}, 32'(bus.resp_valid), 32'h1);
      check({tag, ".err_flag"}, 32'(bus.resp_error), 32'h1);
      check({tag, ".err_rdata"}, bus.resp_rdata, 32'h0);
      check({tag, ".err_strobe"}, 32'({bus.mem_read, bus.mem_write, bus.mem_byteenable}), 32'h0);
    end else begin
      check({tag, ".strobe"}, 32'({bus.mem_read, bus.mem_write}), 32'({~w, w}));
      check({tag, ".address"}, bus.mem_address, e_addr);
      check({tag, ".be"}, 32'(bus.mem_byteenable), 32'(e_be));
      if (w) check({tag, ".wdata"}, bus.mem_wdata, e_wd);
      check({tag, ".busy"}, 32'({bus.req_ready, bus.resp_valid}), 32'h0);
      @(negedge clock);
      check({tag, ".resp"}, 32'({bus.resp_valid, bus.resp_error}), 32'h2);
      check({tag, ".rdata"}, bus.resp_rdata, e_rd);
      check({tag, ".idle_strobe"}, 32'({bus.mem_read, bus.mem_write, bus.mem_byteenable}), 32'h0);
    end
  endtask
  initial begin
    int wr0;
    drive(1'b1, 32'h0, 2'b10, 1'b0, 32'h12345678);
    repeat (3) @(negedge clock);
    check("rst.ready", 32'(bus.req_ready), 32'h0);
    check("rst.outs", 32'({bus.mem_read, bus.mem_write, bus.resp_valid, bus.resp_error}), 32'h0);
    check("rst.nowrite", 32'(n_wr), 32'h0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst.ready", 32'(bus.req_ready), 32'h1);
    check("post_rst.zero", bus.resp_rdata | bus.mem_address | bus.mem_wdata | 32'(bus.mem_byteenable), 32'h0);
    txn("sw10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'd4, 4'b1111, 32'hDEADBEEF, 32'h0);
    txn("lw10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'hDEADBEEF);
    txn("sb13", 1'b1, 32'h13, 2'b00, 1'b0, 32'h000000A5, 1'b0, 32'd4, 4'b1000, 32'hA5A5A5A5, 32'h0);
    txn("lb13s", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'hFFFFFFA5);
    txn("lb13u", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'h000000A5);
    txn("lb12u", 1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'h000000AD);
    txn("sw10b", 1'b1, 32'h10, 2'b10, 1'b0, 32'h80017FFF, 1'b0, 32'd4, 4'b1111, 32'h80017FFF, 32'h0);
    txn("lh12s", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'hFFFF8001);
    txn("lh12u", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'h00008001);
    txn("lh10s", 1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'h00007FFF);
    txn("sh16", 1'b1, 32'h16, 2'b01, 1'b0, 32'hABCD1234, 1'b0, 32'd5, 4'b1100, 32'h12341234, 32'h0);
    txn("lh16u", 1'b0, 32'h16, 2'b01, 1'b0, 32'h0, 1'b0, 32'd5, 4'b0000, 32'h0, 32'h00001234);
    txn("lb17s", 1'b0, 32'h17, 2'b00, 1'b1, 32'h0, 1'b0, 32'd5, 4'b0000, 32'h0, 32'h00000012);
    txn("sw_top", 1'b1, 32'h3FFFC, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 32'hFFFF, 4'b1111, 32'hCAFEF00D, 32'h0);
    txn("lw_top", 1'b0, 32'h3FFFC, 2'b10, 1'b0, 32'h0, 1'b0, 32'hFFFF, 4'b0000, 32'h0, 32'hCAFEF00D);
    wr0 = n_wr;
    txn("lw06", 1'b0, 32'h06, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
    txn("lh03", 1'b0, 32'h03, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
    txn("sz11", 1'b1, 32'h10, 2'b11, 1'b0, 32'h1, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
    txn("range", 1'b1, 32'h40000, 2'b10, 1'b0, 32'h1, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0);
    check("err.nowrite", 32'(n_wr), 32'(wr0));
    @(negedge clock);
    drive(1'b1, 32'h10, 2'b10, 1'b0, 32'h11111111);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rstacc.write", 32'({bus.mem_write, bus.mem_byteenable}), 32'h0);
    check("rstacc.valid", 32'(bus.resp_valid), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rstacc.ready", 32'(bus.req_ready), 32'h1);
    check("rstacc.valid2", 32'(bus.resp_valid), 32'h0);
    txn("rstacc.lw", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'd4, 4'b0000, 32'h0, 32'h80017FFF);
    @(negedge clock);
    drive(1'b1, 32'h20, 2'b10, 1'b0, 32'h55AA55AA);
    check("b2b.r0", 32'(bus.req_ready), 32'h1);
    @(posedge clock);
    #1 bus.req_wdata = 32'h0F0F0F0F;
    @(negedge clock);
    check("b2b.r1", 32'(bus.req_ready), 32'h0);
    check("b2b.wd1", bus.mem_wdata, 32'h55AA55AA);
    @(negedge clock);
    check("b2b.r2", 32'({bus.req_ready, bus.resp_valid}), 32'h1);
    @(negedge clock);
    check("b2b.r3", 32'(bus.req_ready), 32'h1);
    @(posedge clock);
    #1 drive(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
    @(negedge clock);
    check("b2b.r4", 32'({bus.req_ready, bus.mem_write}), 32'h1);
    check("b2b.wd4", bus.mem_wdata, 32'h0F0F0F0F);
    @(negedge clock);
    check("b2b.r5", 32'({bus.req_ready, bus.resp_valid}), 32'h1);
    @(negedge clock);
    check("b2b.r6", 32'(bus.req_ready), 32'h1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    check("b2b.rd", 32'(bus.mem_read), 32'h1);
    @(negedge clock);
    check("b2b.rdata", bus.resp_rdata, 32'h0F0F0F0F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter offset, default 32'h00000000, meaning the byte base address of the attached ram.
REQ-002 The block SHALL have parameter size, default 65536, meaning the ram depth in 32-bit words.
REQ-003 The block SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  CPU load/store request present.
REQ-006 The block SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 The block SHALL have port req_signed  input  1  load sign-extends when 1 and zero-extends when 0.
REQ-011 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 The block SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port resp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-014 The block SHALL have port resp_error  output  1  address error, qualified by resp_valid.
REQ-015 The block SHALL have ports mem_read, mem_write (output, 1 bit each), mem_address (output, 32), mem_byteenable (output, 4), mem_wdata (output, 32) and mem_rdata (input, 32), connecting to the ram port of the same names.

Function
REQ-016 The unit SHALL have FSM states IDLE, ACCESS, RESP and ERR; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid & req_ready; all req_* fields SHALL be registered at acceptance and req_* changes after acceptance SHALL be ignored.
REQ-018 A request SHALL be an error when: req_size==11; half with addr[0]!=0; word with addr[1:0]!=0; req_addr<offset; or ((req_addr-offset)>>2)>=size.
REQ-019 On acceptance, an error request SHALL go IDLE->ERR and a legal request SHALL go IDLE->ACCESS.
REQ-020 ERR SHALL drive resp_valid=1, resp_error=1 and resp_rdata=0, issue no mem strobe, and return to IDLE.
REQ-021 In ACCESS, mem_address SHALL equal (req_addr-offset)>>2 and exactly one of mem_read/mem_write SHALL be 1, for exactly one cycle; the state SHALL then go to RESP.
REQ-022 Byte lane SHALL be lane=addr[1:0], little-endian, with lane k mapping to bits [8k+7:8k] and byteenable[k].
REQ-023 mem_byteenable SHALL be 4'b0001<<lane for byte, 4'b0011<<lane for half and 4'b1111 for word; it SHALL be 0 for loads.
REQ-024 mem_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half and wdata for word.
REQ-025 RESP SHALL assert resp_valid=1 and resp_error=0 for one cycle, then return to IDLE.
REQ-026 For loads in RESP, resp_rdata SHALL be mem_rdata[8*lane+:8] or mem_rdata[16*addr[1]+:16] extended per req_signed, or mem_rdata for word; for stores resp_rdata SHALL be 0.
REQ-027 Latency from acceptance edge to resp_valid SHALL be 2 cycles for a legal request and 1 cycle for an error; throughput SHALL be one request per 3 cycles (per 2 for errors).
REQ-028 resp_valid SHALL have no backpressure; the consumer SHALL sample it in the asserted cycle.
REQ-029 Outside ACCESS, mem_read, mem_write and mem_byteenable SHALL be 0.

Reset
REQ-030 While reset=1, the unit SHALL force the state to IDLE at the next edge, and mem_read, mem_write, resp_valid and resp_error SHALL be 0 combinationally.
REQ-031 After reset, req_ready SHALL be 1 and resp_rdata, mem_address, mem_wdata and mem_byteenable SHALL be 0.
REQ-032 If reset is asserted in ACCESS or RESP, the in-flight request SHALL be dropped with no ram write and no resp_valid.
REQ-033 A request presented during reset SHALL not be accepted.

Verification
REQ-034 Store word 0xDEADBEEF at 0x10 (offset 0) -> ACCESS: mem_address=4, byteenable=1111, mem_write=1; resp_valid 2 cycles after acceptance.
REQ-035 Store byte 0xA5 at 0x13, then signed load byte at 0x13 -> byteenable=1000, wdata=0xA5A5A5A5; load resp_rdata=0xFFFFFFA5; unsigned load gives 0x000000A5.
REQ-036 Load half from 0x12 with word 0x8001_7FFF stored -> signed 0xFFFF8001, unsigned 0x00008001.
REQ-037 Word load at 0x06, half at 0x03, size=11, and addr=offset+4*size -> resp_error=1 one cycle after acceptance, rdata=0, no mem strobe.
REQ-038 Reset asserted during ACCESS of a store -> mem_write=0 that cycle, target word unchanged, no resp_valid, req_ready=1 after reset.
REQ-039 Back-to-back req_valid held high -> accepts every 3rd cycle; req_ready=0 in ACCESS and RESP; req_wdata changed mid-flight does not alter the write.
